// File: rtl/pipe_scheduler.sv
// pipe_scheduler: game-flow FSM and column timing for a scrolling pipe game.
// A tick counter produces shift_tick every `period` cycles while playing.
// Each tick either loads a new pipe (load_pipe) or inserts a blank column,
// with GAP_COLS blanks between pipes. sel picks a pattern from a free-running LFSR.
// Optional feature: define PIPE_SCHED_SPEEDUP_EN to shorten the period by STEP
// (floored at MIN_PERIOD) every 8 pipes. Without it the period stays at BASE_PERIOD.

module pipe_scheduler #(
   parameter int         BASE_PERIOD = 2560,
   parameter int         MIN_PERIOD  = 640,
   parameter int         STEP        = 128,
   parameter int         GAP_COLS    = 3,
   parameter logic [7:0] SEED        = 8'hB5   // must be nonzero or the LFSR locks up
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       lossDetect,
   output logic       shift_tick,
   output logic       load_pipe,
   output logic       blank,
   output logic [3:0] sel,
   output logic [7:0] score,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      LOST = 2'b10
   } state_t;

   localparam int               COL_W    = (GAP_COLS > 0) ? $clog2(GAP_COLS + 1) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(GAP_COLS);
   localparam logic [11:0]      BASE_P   = 12'(BASE_PERIOD);
   localparam logic [11:0]      MIN_P    = 12'(MIN_PERIOD);
   localparam logic [11:0]      STEP_P   = 12'(STEP);

   state_t           state_q, state_d;
   logic [11:0]      tick_cnt;
   logic [11:0]      period;
   logic [11:0]      period_dec;
   logic [COL_W-1:0] col_cnt;
   logic [7:0]       lfsr;
   logic [7:0]       score_inc;
   logic             lfsr_fb;
   logic             tick_due;
   logic             enter_play;
   logic             advance;
   logic             speed_step;

   // Next-state logic and tick/column pulse decode
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
      state_d    = state_q;
      enter_play = 1'b0;
      tick_due   = (state_q == PLAY) && (tick_cnt == period - 12'd1);
      shift_tick = tick_due && !lossDetect;          // a collision swallows the tick
      load_pipe  = shift_tick && (col_cnt == '0);
      blank      = shift_tick && (col_cnt != '0);
      advance    = (state_q == PLAY) && !lossDetect; // counters freeze on the losing cycle
      case (state_q)
         IDLE: if (start) begin
            state_d    = PLAY;
            enter_play = 1'b1;
         end
         PLAY:    if (lossDetect) state_d = LOST;
         LOST:    if (start)      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign score_inc  = score + 8'd1;
   assign period_dec = (period >= MIN_P + STEP_P) ? period - STEP_P : MIN_P;

`ifdef PIPE_SCHED_SPEEDUP_EN
   // Speed up on the load that brings score to a nonzero multiple of 8;
   // a saturated score never triggers again.
   assign speed_step = load_pipe && (score != 8'hFF) && (score_inc[2:0] == 3'd0);
`else
   assign speed_step = 1'b0;
`endif

   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];  // x^8+x^6+x^5+x^4+1
   assign state   = state_q;

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Free-running pattern LFSR, steps in every state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) lfsr <= SEED;
      else        lfsr <= {lfsr[6:0], lfsr_fb};
   end

   // Game counters: tick timing, column phase, score, pattern select, period
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         col_cnt  <= '0;
         score    <= '0;
         sel      <= '0;
         period   <= BASE_P;
      end else if (enter_play) begin
         tick_cnt <= '0;
         col_cnt  <= '0;
         score    <= '0;
         sel      <= lfsr[3:0];
         period   <= BASE_P;
      end else if (advance) begin
         tick_cnt <= tick_due ? 12'd0 : tick_cnt + 12'd1;
         if (shift_tick)
            col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + COL_W'(1);
         if (load_pipe) begin
            // sel changes on the load edge, so it is stable while load_pipe is high
            sel <= lfsr[3:0];
            if (score != 8'hFF) score <= score_inc;
         end
         // Period only changes on a load tick, which is also a tick_cnt wrap,
         // so the new spacing applies from the next count cycle.
         if (speed_step) period <= period_dec;
      end
   end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Testbench for pipe_scheduler with BASE_PERIOD=4, MIN_PERIOD=2, STEP=1, GAP_COLS=1.
// A cycle table covers start/loss/restart; a monitor scoreboards tick spacing,
// sel and the LFSR; hand sequences cover speed-up, saturation and mid-game reset.

module tb_pipe_scheduler;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_PLAY = 2'b01;
   localparam logic [1:0] S_LOST = 2'b10;

   logic       clock;
   logic       reset;
   logic       start;
   logic       lossDetect;
   logic       shift_tick;
   logic       load_pipe;
   logic       blank;
   logic [3:0] sel;
   logic [7:0] score;
   logic [1:0] state;

   typedef struct packed {
      logic       start;
      logic       loss;
      logic [1:0] st;
      logic       tick;
      logic       load;
      logic       blank;
      logic [7:0] score;
   } vec_t;

   typedef struct packed {
      logic [15:0] spacing;
      logic        load;
      logic        blank;
   } tick_t;

   vec_t       vecs [27];
   tick_t      tick_q [$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         last_tick = 0;
   int         load_count = 0;
   logic [3:0] exp_sel = 4'd0;
   logic [7:0] m_lfsr;
   logic       lfsr_zero_seen = 1'b0;

   pipe_scheduler #(
      .BASE_PERIOD(4),
      .MIN_PERIOD (2),
      .STEP       (1),
      .GAP_COLS   (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .lossDetect(lossDetect),
      .shift_tick(shift_tick),
      .load_pipe (load_pipe),
      .blank     (blank),
      .sel       (sel),
      .score     (score),
      .state     (state)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, taps at exponents 8,6,5,4
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], ^(v & 8'hB8)};
   endfunction

   function automatic vec_t mk(input int s, input int l, input int st, input int t,
                               input int ld, input int b, input int sc);
      vec_t v;
      v.start = s[0];
      v.loss  = l[0];
      v.st    = st[1:0];
      v.tick  = t[0];
      v.load  = ld[0];
      v.blank = b[0];
      v.score = sc[7:0];
      return v;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) m_lfsr <= 8'hB5;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   // Monitor: samples mid-cycle, after the driver has settled the inputs
   initial begin
      tick_t e;
      forever begin
         @(negedge clock);
         #3;
         cyc++;
         check("lfsr_model", {24'd0, dut.lfsr}, {24'd0, m_lfsr});
         if (dut.lfsr == 8'd0) lfsr_zero_seen = 1'b1;
         if (!reset) begin
            exp_sel = 4'd0;
         end else begin
            check("sel", {28'd0, sel}, {28'd0, exp_sel});
            if (state != S_PLAY)
               check("quiet_outside_play", {29'd0, shift_tick, load_pipe, blank}, 32'd0);
            if (shift_tick) begin
               check("load_xor_blank", {31'd0, load_pipe ^ blank}, 32'd1);
               if (tick_q.size() > 0) begin
                  e = tick_q.pop_front();
                  check("tick_spacing", cyc - last_tick, {16'd0, e.spacing});
                  check("tick_load", {31'd0, load_pipe}, {31'd0, e.load});
                  check("tick_blank", {31'd0, blank}, {31'd0, e.blank});
               end
               last_tick = cyc;
            end
            if (load_pipe) load_count++;
            if (state == S_IDLE && start) begin
               exp_sel   = m_lfsr[3:0];
               last_tick = cyc;
            end else if (load_pipe) begin
               exp_sel = m_lfsr[3:0];
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clock);
      reset      = 1'b0;
      start      = 1'b0;
      lossDetect = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      int base;
      tick_t t;
      reset      = 1'b0;
      start      = 1'b0;
      lossDetect = 1'b0;

      vecs = '{
         mk(0,0,S_IDLE,0,0,0,0), mk(1,0,S_IDLE,0,0,0,0),
         mk(0,0,S_PLAY,0,0,0,0), mk(0,0,S_PLAY,0,0,0,0), mk(0,0,S_PLAY,0,0,0,0),
         mk(0,0,S_PLAY,1,1,0,0),
         mk(0,0,S_PLAY,0,0,0,1), mk(0,0,S_PLAY,0,0,0,1), mk(0,0,S_PLAY,0,0,0,1),
         mk(0,0,S_PLAY,1,0,1,1),
         mk(0,0,S_PLAY,0,0,0,1), mk(0,0,S_PLAY,0,0,0,1), mk(0,0,S_PLAY,0,0,0,1),
         mk(0,0,S_PLAY,1,1,0,1),
         mk(0,0,S_PLAY,0,0,0,2), mk(0,0,S_PLAY,0,0,0,2), mk(0,0,S_PLAY,0,0,0,2),
         mk(0,1,S_PLAY,0,0,0,2),
         mk(0,0,S_LOST,0,0,0,2), mk(0,1,S_LOST,0,0,0,2), mk(1,0,S_LOST,0,0,0,2),
         mk(0,0,S_IDLE,0,0,0,2), mk(1,0,S_IDLE,0,0,0,2),
         mk(1,0,S_PLAY,0,0,0,0), mk(1,0,S_PLAY,0,0,0,0),
         mk(0,1,S_PLAY,0,0,0,0), mk(0,0,S_LOST,0,0,0,0)
      };

      // Reset state
      repeat (2) @(negedge clock);
      #1;
      check("rst_state", {30'd0, state}, {30'd0, S_IDLE});
      check("rst_pulses", {29'd0, shift_tick, load_pipe, blank}, 32'd0);
      check("rst_score", {24'd0, score}, 32'd0);
      check("rst_sel", {28'd0, sel}, 32'd0);
      check("rst_lfsr", {24'd0, dut.lfsr}, 32'hB5);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("release_pulses", {29'd0, shift_tick, load_pipe, blank}, 32'd0);

      // Cycle table: first game, loss on a would-be tick, restart, start held in play
      for (int i = 0; i < 27; i++) begin
         @(negedge clock);
         start      = vecs[i].start;
         lossDetect = vecs[i].loss;
         #1;
         check($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, vecs[i].st});
         check($sformatf("v%0d_tick", i), {31'd0, shift_tick}, {31'd0, vecs[i].tick});
         check($sformatf("v%0d_load", i), {31'd0, load_pipe}, {31'd0, vecs[i].load});
         check($sformatf("v%0d_blank", i), {31'd0, blank}, {31'd0, vecs[i].blank});
         check($sformatf("v%0d_score", i), {24'd0, score}, {24'd0, vecs[i].score});
      end

      // Speed-up sequence: 50 ticks, pipes on odd ticks
      do_reset();
      @(negedge clock);
      for (int k = 1; k <= 50; k++) begin
`ifdef PIPE_SCHED_SPEEDUP_EN
         t.spacing = (k <= 15) ? 16'd4 : (k <= 31) ? 16'd3 : 16'd2;
`else
         t.spacing = 16'd4;
`endif
         t.load  = k[0];
         t.blank = ~k[0];
         tick_q.push_back(t);
      end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 1000 && tick_q.size() != 0; i++) @(negedge clock);
      check("speed_ticks_drained", tick_q.size(), 32'd0);
      tick_q.delete();
      lossDetect = 1'b1;
      #1;
      check("speed_score", {24'd0, score}, 32'd25);
      check("speed_loss_no_tick", {31'd0, shift_tick}, 32'd0);
      @(negedge clock);
      lossDetect = 1'b0;
      #1;
      check("speed_lost", {30'd0, state}, {30'd0, S_LOST});

      // Saturation: run past 300 pipes
      do_reset();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      base  = load_count;
      for (int i = 0; i < 4000 && (load_count - base) < 300; i++) @(negedge clock);
      check("sat_loads_reached", {31'd0, (load_count - base) >= 300}, 32'd1);
      check("sat_score", {24'd0, score}, 32'd255);
      lossDetect = 1'b1;
      @(negedge clock);
      lossDetect = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check("sat_lost_state", {30'd0, state}, {30'd0, S_LOST});
      check("sat_lost_score", {24'd0, score}, 32'd255);
      check("lfsr_never_zero", {31'd0, lfsr_zero_seen}, 32'd0);

      // Start held through play, then reset mid-game
      do_reset();
      @(negedge clock);
      start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         #1;
         check($sformatf("hold_start_play_%0d", i), {30'd0, state}, {30'd0, S_PLAY});
      end
      check("hold_start_score", {24'd0, score}, 32'd1);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("midrst_state", {30'd0, state}, {30'd0, S_IDLE});
      check("midrst_pulses", {29'd0, shift_tick, load_pipe, blank}, 32'd0);
      check("midrst_score", {24'd0, score}, 32'd0);
      check("midrst_sel", {28'd0, sel}, 32'd0);
      check("midrst_lfsr", {24'd0, dut.lfsr}, 32'hB5);
      @(negedge clock);
      reset = 1'b1;
      start = 1'b0;
      #1;
      check("midrst_release_state", {30'd0, state}, {30'd0, S_IDLE});
      @(negedge clock);
      #1;
      check("midrst_after_pulses", {29'd0, shift_tick, load_pipe, blank}, 32'd0);
      check("midrst_after_state", {30'd0, state}, {30'd0, S_IDLE});

      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 SHALL have parameter BASE_PERIOD, 2560, clock cycles per column shift at game start.
REQ-002 SHALL have parameter MIN_PERIOD, 640, floor on the shift period.
REQ-003 SHALL have parameter STEP, 128, period decrement per speed-up.
REQ-004 SHALL have parameter GAP_COLS, 3, blank columns between consecutive pipes.
REQ-005 SHALL have parameter SEED, 8'hB5, nonzero LFSR reset value.
REQ-006 SHALL have port clock, input, 1, sole clock; all state on posedge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, synchronous start/restart request.
REQ-009 SHALL have port lossDetect, input, 1, collision flag from game logic.
REQ-010 SHALL have port shift_tick, output, 1, one-cycle pulse advancing all pipe columns.
REQ-011 SHALL have port load_pipe, output, 1, one-cycle pulse, new pipe enters at right edge.
REQ-012 SHALL have port blank, output, 1, high with a shift_tick that inserts an empty column.
REQ-013 SHALL have port sel, output, 4, pipe pattern select for the pipe generator.
REQ-014 SHALL have port score, output, 8, pipes issued this game.
REQ-015 SHALL have port state, output, 2, IDLE=00, PLAY=01, LOST=10.

Function
REQ-016 SHALL implement FSM IDLE -> PLAY on start; PLAY -> LOST on lossDetect; LOST -> IDLE on start; start ignored in PLAY; lossDetect ignored in IDLE and LOST.
REQ-017 SHALL, on IDLE -> PLAY, clear tick_cnt, col_cnt and score and load period with BASE_PERIOD.
REQ-018 SHALL, in PLAY, increment 12-bit tick_cnt each cycle and wrap it to 0 at period-1.
REQ-019 SHALL drive shift_tick combinationally as state==PLAY and tick_cnt==period-1 and !lossDetect; the first tick occurs period cycles after the start edge.
REQ-020 SHALL assert load_pipe with a shift_tick when col_cnt==0, and blank with a shift_tick when col_cnt!=0; never both.
REQ-021 SHALL advance col_cnt modulo GAP_COLS+1 on each shift_tick.
REQ-022 SHALL step an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) every cycle in all states; the LFSR never reaches zero.
REQ-023 SHALL register sel from lfsr[3:0] on entry to PLAY and on each load_pipe, holding sel stable while load_pipe is high.
REQ-024 SHALL increment score on load_pipe, saturating at 255.
REQ-025 SHALL, when lossDetect and a would-be tick coincide, suppress the tick and enter LOST.
REQ-026 SHALL hold tick_cnt, col_cnt, score, sel and period frozen in LOST and IDLE; shift_tick, load_pipe and blank are 0 there.

Reset
REQ-027 SHALL, on reset low, immediately force state=IDLE, tick_cnt=0, col_cnt=0, score=0, sel=0, period=BASE_PERIOD and lfsr=SEED, including mid-PLAY.
REQ-028 SHALL hold shift_tick, load_pipe and blank at 0 while reset is low and in the first cycle after release.

Configuration
REQ-029 SHALL, with PIPE_SCHED_SPEEDUP_EN defined, reduce period by STEP (floor MIN_PERIOD) at each load_pipe that makes score a nonzero multiple of 8, effective from the next tick_cnt wrap.
REQ-030 SHALL, without PIPE_SCHED_SPEEDUP_EN, hold period at BASE_PERIOD for the whole game.

Verification (BASE_PERIOD=4, MIN_PERIOD=2, STEP=1, GAP_COLS=1)
REQ-031 Start pulse from IDLE -> state=01; shift_tick+load_pipe at start edge+4 cycles; score=1; next tick 4 cycles later has blank=1 and load_pipe=0.
REQ-032 lossDetect high in a cycle with tick_cnt==3 -> no shift_tick; state=10; score/sel frozen; start -> state=00; next start -> score=0.
REQ-033 Macro defined, 8 loads (score=8) -> tick spacing becomes 3, then 2 after score=16, remains 2 at score=24.
REQ-034 Macro undefined, same stimulus -> tick spacing stays 4 throughout.
REQ-035 Reset low mid-PLAY for 1 cycle -> all outputs 0, state=00, lfsr=8'hB5; start held high throughout PLAY -> no restart.
REQ-036 Run to 300 loads (forced/long sim) -> score saturates at 255; LFSR never observed at 0.
